// File: rtl/dso_cap_ctrl.sv
// rtl/dso_cap_ctrl.sv - capture sequencer for a sampled acquisition buffer
//
// Ports:
//   clk, nrst              sample-domain clock, asynchronous active-low reset
//   smp_en                 one sample valid this cycle
//   arm, abort, force_trig capture control (abort has priority over arm)
//   pre_len, post_len      sample counts before / after the trigger sample
//   trig_pluse             one-cycle trigger event from the trigger block
//   trig_clr               holds the trigger block cleared outside WAIT/POST
//   wr_en, wr_addr         buffer write strobe and address of this write
//   trig_addr              buffer address of the trigger sample
//   busy, done, state      status and raw FSM state code
module dso_cap_ctrl (
    input  logic        clk,
    input  logic        nrst,
    input  logic        smp_en,
    input  logic        arm,
    input  logic        abort,
    input  logic        force_trig,
    input  logic [11:0] pre_len,
    input  logic [11:0] post_len,
    input  logic        trig_pluse,
    output logic        trig_clr,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [11:0] trig_addr,
    output logic        busy,
    output logic        done,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      st;
    logic [11:0] pre_lat;
    logic [11:0] post_lat;
    // Shared sample counter: counts PRE writes, then is cleared on trigger
    // and reused for POST writes.
    logic [11:0] cnt;

    assign state    = st;
    assign busy     = (st == S_PRE) || (st == S_WAIT) || (st == S_POST);
    assign done     = (st == S_DONE);
    assign trig_clr = !((st == S_WAIT) || (st == S_POST));
    assign wr_en    = smp_en && busy;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            st        <= S_IDLE;
            wr_addr   <= 12'd0;
            trig_addr <= 12'd0;
            cnt       <= 12'd0;
            pre_lat   <= 12'd0;
            post_lat  <= 12'd0;
        end else if (abort) begin
            // Pointers deliberately hold so software can inspect them.
            st <= S_IDLE;
        end else if (arm) begin
            st       <= S_PRE;
            wr_addr  <= 12'd0;
            cnt      <= 12'd0;
            pre_lat  <= pre_len;
            post_lat <= post_len;
        end else begin
            // Free-running circular pointer; overrun is not policed.
            if (wr_en) begin
                wr_addr <= wr_addr + 12'd1;
            end
            case (st)
                S_PRE: begin
                    if (pre_lat == 12'd0) begin
                        st <= S_WAIT;
                    end else if (wr_en) begin
                        cnt <= cnt + 12'd1;
                        if (cnt + 12'd1 == pre_lat) begin
                            st <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // The write in this cycle is the trigger sample and is
                    // not counted toward post_len.
                    if (trig_pluse || force_trig) begin
                        trig_addr <= wr_addr;
                        cnt       <= 12'd0;
                        st        <= S_POST;
                    end
                end
                S_POST: begin
                    if (post_lat == 12'd0) begin
                        st <= S_DONE;
                    end else if (wr_en) begin
                        cnt <= cnt + 12'd1;
                        if (cnt + 12'd1 == post_lat) begin
                            st <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    st <= S_DONE;
                end
                default: begin
                    st <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dso_cap_ctrl.sv
// tb/tb_dso_cap_ctrl.sv - self-checking bench for dso_cap_ctrl
module tb_dso_cap_ctrl;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        smp_en = 1'b0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic        force_trig = 1'b0;
    logic [11:0] pre_len = 12'd0;
    logic [11:0] post_len = 12'd0;
    logic        trig_pluse = 1'b0;
    logic        trig_clr;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [11:0] trig_addr;
    logic        busy;
    logic        done;
    logic [2:0]  state;

    int checks = 0;
    int failures = 0;

    logic [11:0] wq[$];
    logic [2:0]  ws[$];

    dso_cap_ctrl dut (
        .clk(clk), .nrst(nrst), .smp_en(smp_en), .arm(arm), .abort(abort),
        .force_trig(force_trig), .pre_len(pre_len), .post_len(post_len),
        .trig_pluse(trig_pluse), .trig_clr(trig_clr), .wr_en(wr_en),
        .wr_addr(wr_addr), .trig_addr(trig_addr), .busy(busy), .done(done),
        .state(state)
    );

    always #5 clk = ~clk;

    // Record every buffer write with the state it happened in.
    always @(negedge clk) begin
        if (nrst && wr_en) begin
            wq.push_back(wr_addr);
            ws.push_back(state);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic arm_pulse(input logic [11:0] p, input logic [11:0] q);
        pre_len  = p;
        post_len = q;
        wq.delete();
        ws.delete();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim, input string nm);
        int n = 0;
        while (state !== s && n < lim) begin
            tick();
            n++;
        end
        checks++;
        if (state !== s) begin
            failures++;
            $display("FAIL %s timeout: state=%0d expected %0d", nm, state, s);
        end
    endtask

    task automatic abort_pulse;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset;
        smp_en = 1'b1;
        nrst = 1'b0;
        tick();
        tick();
        checks += 7;
        if (state !== 3'd0)       begin failures++; $display("FAIL rst_state: got %0d want 0", state); end
        if (wr_en !== 1'b0)       begin failures++; $display("FAIL rst_wr_en: got %0b want 0", wr_en); end
        if (trig_clr !== 1'b1)    begin failures++; $display("FAIL rst_trig_clr: got %0b want 1", trig_clr); end
        if (busy !== 1'b0)        begin failures++; $display("FAIL rst_busy: got %0b want 0", busy); end
        if (done !== 1'b0)        begin failures++; $display("FAIL rst_done: got %0b want 0", done); end
        if (wr_addr !== 12'd0)    begin failures++; $display("FAIL rst_wr_addr: got %0d want 0", wr_addr); end
        if (trig_addr !== 12'd0)  begin failures++; $display("FAIL rst_trig_addr: got %0d want 0", trig_addr); end
        nrst = 1'b1;
        smp_en = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        int np;
        int npost;
        int qs;
        smp_en = 1'b1;
        arm_pulse(12'd4, 12'd3);
        wait_state(3'd2, 20, "basic_wait");
        repeat (10) tick();
        trig_pluse = 1'b1;
        tick();
        trig_pluse = 1'b0;
        wait_state(3'd4, 20, "basic_done");
        checks += 2;
        if (done !== 1'b1)        begin failures++; $display("FAIL basic_done: got %0b want 1", done); end
        if (trig_addr !== 12'd14) begin failures++; $display("FAIL basic_trig_addr: got %0d want 14", trig_addr); end
        np = 0;
        npost = 0;
        foreach (wq[i]) begin
            if (ws[i] == 3'd1) begin
                checks++;
                if (wq[i] !== 12'(np)) begin failures++; $display("FAIL basic_pre_addr: got %0d want %0d", wq[i], np); end
                np++;
            end
            if (ws[i] == 3'd3) begin
                checks++;
                if (wq[i] !== 12'(15 + npost)) begin failures++; $display("FAIL basic_post_addr: got %0d want %0d", wq[i], 15 + npost); end
                npost++;
            end
        end
        checks += 2;
        if (np != 4)    begin failures++; $display("FAIL basic_pre_count: got %0d want 4", np); end
        if (npost != 3) begin failures++; $display("FAIL basic_post_count: got %0d want 3", npost); end
        qs = wq.size();
        repeat (3) tick();
        checks += 2;
        if (wr_en !== 1'b0)   begin failures++; $display("FAIL basic_done_wr_en: got %0b want 0", wr_en); end
        if (wq.size() != qs)  begin failures++; $display("FAIL basic_done_writes: got %0d want %0d", wq.size(), qs); end
        smp_en = 1'b0;
    endtask

    task automatic test_pre_ignore;
        int clr_bad = 0;
        int n = 0;
        arm_pulse(12'd8, 12'd2);
        while (state == 3'd1 && n < 100) begin
            smp_en     = 1'($urandom_range(0, 1));
            trig_pluse = (n == 2 || n == 5);
            if (trig_clr !== 1'b1) clr_bad++;
            tick();
            n++;
        end
        trig_pluse = 1'b0;
        smp_en = 1'b0;
        checks += 4;
        if (clr_bad != 0)      begin failures++; $display("FAIL pre_trig_clr: bad cycles %0d want 0", clr_bad); end
        if (state !== 3'd2)    begin failures++; $display("FAIL pre_to_wait: state=%0d want 2", state); end
        if (wq.size() != 8)    begin failures++; $display("FAIL pre_writes: got %0d want 8", wq.size()); end
        if (wr_addr !== 12'd8) begin failures++; $display("FAIL pre_wr_addr: got %0d want 8", wr_addr); end
        abort_pulse();
    endtask

    task automatic test_zero_len;
        smp_en = 1'b1;
        arm_pulse(12'd0, 12'd0);
        checks++;
        if (state !== 3'd1) begin failures++; $display("FAIL zero_pre: state=%0d want 1", state); end
        tick();
        checks++;
        if (state !== 3'd2) begin failures++; $display("FAIL zero_wait: state=%0d want 2", state); end
        force_trig = 1'b1;
        tick();
        force_trig = 1'b0;
        checks += 2;
        if (state !== 3'd3)      begin failures++; $display("FAIL zero_post: state=%0d want 3", state); end
        if (trig_addr !== 12'd1) begin failures++; $display("FAIL zero_trig_addr: got %0d want 1", trig_addr); end
        tick();
        checks++;
        if (state !== 3'd4) begin failures++; $display("FAIL zero_done: state=%0d want 4", state); end
        smp_en = 1'b0;
    endtask

    task automatic test_wrap;
        int np = 0;
        int npost = 0;
        bit wrapped = 0;
        smp_en = 1'b1;
        arm_pulse(12'd4090, 12'd3);
        wait_state(3'd2, 5000, "wrap_wait");
        repeat (10) tick();
        trig_pluse = 1'b1;
        tick();
        trig_pluse = 1'b0;
        wait_state(3'd4, 20, "wrap_done");
        foreach (wq[i]) begin
            if (ws[i] == 3'd1) np++;
            if (i > 0 && wq[i-1] == 12'd4095 && wq[i] == 12'd0) wrapped = 1;
            if (ws[i] == 3'd3) begin
                checks++;
                if (wq[i] !== 12'(5 + npost)) begin failures++; $display("FAIL wrap_post_addr: got %0d want %0d", wq[i], 5 + npost); end
                npost++;
            end
        end
        checks += 3;
        if (np != 4090)          begin failures++; $display("FAIL wrap_pre_count: got %0d want 4090", np); end
        if (!wrapped)            begin failures++; $display("FAIL wrap_pointer: no 4095->0 step seen, want one"); end
        if (trig_addr !== 12'd4) begin failures++; $display("FAIL wrap_trig_addr: got %0d want 4", trig_addr); end
        smp_en = 1'b0;
    endtask

    task automatic test_abort_arm;
        smp_en = 1'b1;
        arm_pulse(12'd2, 12'd20);
        wait_state(3'd2, 20, "aa_wait");
        trig_pluse = 1'b1;
        tick();
        trig_pluse = 1'b0;
        repeat (3) tick();
        abort = 1'b1;
        arm = 1'b1;
        tick();
        abort = 1'b0;
        arm = 1'b0;
        checks += 5;
        if (state !== 3'd0)      begin failures++; $display("FAIL aa_state: got %0d want 0", state); end
        if (done !== 1'b0)       begin failures++; $display("FAIL aa_done: got %0b want 0", done); end
        if (trig_clr !== 1'b1)   begin failures++; $display("FAIL aa_trig_clr: got %0b want 1", trig_clr); end
        if (wr_addr !== 12'd6)   begin failures++; $display("FAIL aa_wr_addr_hold: got %0d want 6", wr_addr); end
        if (trig_addr !== 12'd2) begin failures++; $display("FAIL aa_trig_addr_hold: got %0d want 2", trig_addr); end
        arm_pulse(12'd2, 12'd20);
        checks += 2;
        if (state !== 3'd1)    begin failures++; $display("FAIL aa_rearm_state: got %0d want 1", state); end
        if (wr_addr !== 12'd0) begin failures++; $display("FAIL aa_rearm_wr_addr: got %0d want 0", wr_addr); end
        smp_en = 1'b0;
        abort_pulse();
    endtask

    task automatic test_reset_mid;
        int bad = 0;
        smp_en = 1'b1;
        arm_pulse(12'd3, 12'd5);
        wait_state(3'd2, 20, "rm_wait");
        repeat (2) tick();
        nrst = 1'b0;
        #1;
        checks += 4;
        if (state !== 3'd0)      begin failures++; $display("FAIL rm_state: got %0d want 0", state); end
        if (wr_addr !== 12'd0)   begin failures++; $display("FAIL rm_wr_addr: got %0d want 0", wr_addr); end
        if (trig_addr !== 12'd0) begin failures++; $display("FAIL rm_trig_addr: got %0d want 0", trig_addr); end
        if (wr_en !== 1'b0)      begin failures++; $display("FAIL rm_wr_en: got %0b want 0", wr_en); end
        tick();
        nrst = 1'b1;
        trig_pluse = 1'b1;
        repeat (5) begin
            tick();
            if (wr_en !== 1'b0 || state !== 3'd0) bad++;
        end
        trig_pluse = 1'b0;
        smp_en = 1'b0;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL rm_idle_after: bad cycles %0d want 0", bad); end
    endtask

    // Expected timeline derived from the smp_en sequence by counting samples.
    task automatic test_random;
        bit seq[200];
        int p, q, k, pre_end, t, post_end, done_c, ones, exp_trig, exp_wa;
        bit use_force;
        for (int it = 0; it < 8; it++) begin
            p = $urandom_range(0, 20);
            q = $urandom_range(0, 20);
            k = $urandom_range(0, 15);
            use_force = 1'($urandom_range(0, 1));
            for (int i = 0; i < 200; i++) seq[i] = (i >= 120) ? 1'b1 : ($urandom_range(0, 3) != 0);
            pre_end = 0;
            if (p != 0) begin
                ones = 0;
                for (int i = 0; i < 200; i++) begin
                    ones += int'(seq[i]);
                    if (ones == p) begin pre_end = i; break; end
                end
            end
            t = pre_end + 1 + k;
            exp_trig = 0;
            for (int i = 0; i < t; i++) exp_trig += int'(seq[i]);
            post_end = t + 1;
            if (q != 0) begin
                ones = 0;
                for (int i = t + 1; i < 200; i++) begin
                    ones += int'(seq[i]);
                    if (ones == q) begin post_end = i; break; end
                end
            end
            done_c = post_end + 1;
            exp_wa = 0;
            for (int i = 0; i <= post_end; i++) exp_wa += int'(seq[i]);

            arm_pulse(12'(p), 12'(q));
            for (int c = 0; c <= done_c; c++) begin
                smp_en = seq[c];
                if (c == t) begin
                    trig_pluse = !use_force;
                    force_trig = use_force;
                end else if (c <= pre_end || c > t) begin
                    trig_pluse = ($urandom_range(0, 3) == 0);
                    force_trig = ($urandom_range(0, 3) == 0);
                end else begin
                    trig_pluse = 1'b0;
                    force_trig = 1'b0;
                end
                if (c == pre_end) begin
                    checks++;
                    if (state !== 3'd1) begin failures++; $display("FAIL rnd%0d_pre: state=%0d want 1 at c=%0d", it, state, c); end
                end
                if (c == pre_end + 1) begin
                    checks++;
                    if (state !== 3'd2) begin failures++; $display("FAIL rnd%0d_wait: state=%0d want 2 at c=%0d", it, state, c); end
                end
                if (c == t + 1) begin
                    checks += 2;
                    if (state !== 3'd3) begin failures++; $display("FAIL rnd%0d_post: state=%0d want 3", it, state); end
                    if (trig_addr !== 12'(exp_trig)) begin failures++; $display("FAIL rnd%0d_trig_addr: got %0d want %0d", it, trig_addr, exp_trig); end
                end
                if (c == done_c) begin
                    checks += 4;
                    if (state !== 3'd4) begin failures++; $display("FAIL rnd%0d_done: state=%0d want 4", it, state); end
                    if (wr_addr !== 12'(exp_wa)) begin failures++; $display("FAIL rnd%0d_wr_addr: got %0d want %0d", it, wr_addr, exp_wa); end
                    if (trig_addr !== 12'(exp_trig)) begin failures++; $display("FAIL rnd%0d_trig_hold: got %0d want %0d", it, trig_addr, exp_trig); end
                    if (wr_en !== 1'b0) begin failures++; $display("FAIL rnd%0d_done_wr_en: got %0b want 0", it, wr_en); end
                end else begin
                    tick();
                end
            end
            trig_pluse = 1'b0;
            force_trig = 1'b0;
            smp_en = 1'b0;
            tick();
            checks++;
            if (wq.size() != exp_wa) begin failures++; $display("FAIL rnd%0d_write_count: got %0d want %0d", it, wq.size(), exp_wa); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pre_ignore();
        test_zero_len();
        test_wrap();
        test_abort_arm();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
